traffic_phase_ctrl: RTL and testbench
=====================================

Name: traffic_phase_ctrl

Overview:
Timed, sensor-actuated controller for a two-road intersection: main road and side road. It sequences the lights through green, yellow and all-red clearance phases. Each phase duration is set by a parameter and counted in ticks of an external timebase strobe. Main road rests in green until a latched side-road request arrives and the minimum main-green time has elapsed. Sits between the sensor/timebase logic and the lamp drivers.

Parameters:
MAIN_GREEN_T, 8, minimum main-green duration in ticks (>=1)
MAIN_YELLOW_T, 3, main-yellow duration in ticks (>=1)
SIDE_GREEN_T, 5, side-green duration in ticks (>=1)
SIDE_YELLOW_T, 3, side-yellow duration in ticks (>=1)
ALL_RED_T, 2, all-red clearance duration in ticks (>=1); used for INIT and both clearances
CNT_W, 8, tick counter width; every *_T must be <= 2**CNT_W

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
tick  input  1  timebase strobe, one-cycle pulse; phase timers advance only on tick=1
side_req  input  1  side-road vehicle sensor, level or pulse
main_r  output  1  main red lamp
main_y  output  1  main yellow lamp
main_g  output  1  main green lamp
side_r  output  1  side red lamp
side_y  output  1  side yellow lamp
side_g  output  1  side green lamp
phase  output  3  current state code, for debug and verification
req_pending  output  1  latched side request not yet served

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - In the cycle after rst is sampled high: state=INIT (phase=0), tick counter=0, req_pending=0.
  - Lamps at reset: main_r=1, side_r=1, all other lamps 0.
  - Reset mid-phase aborts immediately to INIT. No yellow is inserted.
- State codes:
  - INIT=0 (both red), MAIN_G=1, MAIN_Y=2, CLR_MS=3 (both red), SIDE_G=4, SIDE_Y=5, CLR_SM=6 (both red).
  - Code 7 is reserved for the optional feature. Without the feature, any illegal code recovers to INIT on the next clock.
- Lamp decode:
  - MAIN_G: main_g=1, side_r=1.
  - MAIN_Y: main_y=1, side_r=1.
  - SIDE_G: side_g=1, main_r=1.
  - SIDE_Y: side_y=1, main_r=1.
  - INIT, CLR_MS, CLR_SM: main_r=1, side_r=1.
  - Exactly one lamp per road is on in every state. Lamps and phase are registered and change on the same clock edge as the state.
- Timer:
  - Counter increments on tick. On each state change it resets to 0.
  - A timed state with duration T expires on the clock where tick=1 and counter==T-1. The state changes on that edge, so a phase lasts exactly T ticks.
- Transitions:
  - INIT -> MAIN_G after ALL_RED_T.
  - MAIN_G -> MAIN_Y on a tick where counter has reached MAIN_GREEN_T-1 (counter saturates there) and req_pending=1. MAIN_G holds indefinitely without a request.
  - MAIN_Y -> CLR_MS after MAIN_YELLOW_T.
  - CLR_MS -> SIDE_G after ALL_RED_T.
  - SIDE_G -> SIDE_Y after SIDE_GREEN_T.
  - SIDE_Y -> CLR_SM after SIDE_YELLOW_T.
  - CLR_SM -> MAIN_G after ALL_RED_T.
- Request latch:
  - side_req=1 in any state sets req_pending.
  - req_pending clears on the edge entering SIDE_G.
  - If side_req is high on that same edge, the clear wins. A new request is accepted from the next cycle on.
- tick=0: state and counter hold; lamps are unchanged.

Optional Feature:
FLASH_MODE_EN
- Defined:
  - Adds input flash (1 bit) and uses state code 7 as FLASH.
  - flash=1 in any state -> FLASH on the next clock, counter=0.
  - In FLASH, main_y and side_r blink together. They toggle on every tick and start at 1 on entry; all other lamps are 0.
  - flash=0 while in FLASH -> INIT on the next clock (full all-red clearance). req_pending is held through FLASH.
  - rst has priority over flash.
- Not defined: no flash port. Code 7 is illegal and recovers to INIT.

Test Plan:
Defaults, tick=1 every cycle:
- Reset release, side_req=0 -> phase 0 for 2 cycles, then phase 1. Stays at phase 1 for 100 cycles; main_g=1, side_r=1.
- side_req pulse 1 cycle at cycle 3 of MAIN_G -> req_pending=1. MAIN_G lasts 8 cycles total, then MAIN_Y 3, CLR_MS 2, SIDE_G 5, SIDE_Y 3, CLR_SM 2, then back to MAIN_G. req_pending=0 from SIDE_G entry.
- side_req held high continuously -> repeating 23-cycle cycle: 8+3+2+5+3+2. No main-green dwell beyond 8 cycles.
- tick pulsed every 4th cycle -> every phase lasts 4x the cycle counts above. With tick=0, the counter is frozen.
- rst asserted during SIDE_G -> next cycle phase=0, main_r=side_r=1, req_pending=0. No yellow is output.
- FLASH_MODE_EN defined, flash=1 during MAIN_Y -> phase=7, main_y/side_r toggle each tick. Dropping flash -> phase 0 for 2 cycles, then MAIN_G.

Source files
------------

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl
// Two-road intersection light sequencer. Main road rests in green until a
// latched side-road request arrives and the minimum main-green time has
// passed. It then runs main yellow, all-red clearance, side green, side yellow
// and all-red clearance, and returns to main green. Phase timers advance only
// on the external tick strobe. Lamps and phase are registered and change on
// the same edge as the state.
//
// Build option: define FLASH_MODE_EN to add the `flash` input and the FLASH
// state (code 7). In FLASH, main yellow and side red blink together on each
// tick. Without the macro, code 7 is illegal and recovers to INIT.
module traffic_phase_ctrl #(
    parameter int MAIN_GREEN_T  = 8,
    parameter int MAIN_YELLOW_T = 3,
    parameter int SIDE_GREEN_T  = 5,
    parameter int SIDE_YELLOW_T = 3,
    parameter int ALL_RED_T     = 2,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       side_req,
`ifdef FLASH_MODE_EN
    input  logic       flash,
`endif
    output logic       main_r,
    output logic       main_y,
    output logic       main_g,
    output logic       side_r,
    output logic       side_y,
    output logic       side_g,
    output logic [2:0] phase,
    output logic       req_pending
);

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_MAIN_G = 3'd1,
        ST_MAIN_Y = 3'd2,
        ST_CLR_MS = 3'd3,
        ST_SIDE_G = 3'd4,
        ST_SIDE_Y = 3'd5,
        ST_CLR_SM = 3'd6,
        ST_FLASH  = 3'd7
    } state_t;

    // Last counter value of each timed phase. The phase expires on the tick
    // seen at this value, so it lasts exactly T ticks.
    localparam logic [CNT_W-1:0] MG_LAST = CNT_W'(MAIN_GREEN_T - 1);
    localparam logic [CNT_W-1:0] MY_LAST = CNT_W'(MAIN_YELLOW_T - 1);
    localparam logic [CNT_W-1:0] SG_LAST = CNT_W'(SIDE_GREEN_T - 1);
    localparam logic [CNT_W-1:0] SY_LAST = CNT_W'(SIDE_YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALL_RED_T - 1);

    // Lamp vector order: {main_r, main_y, main_g, side_r, side_y, side_g}
    localparam logic [5:0] LAMPS_ALL_RED = 6'b100_100;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             blink;
    logic             blink_nxt;
    logic             flash_on;

`ifdef FLASH_MODE_EN
    assign flash_on = flash;
`else
    assign flash_on = 1'b0;
`endif

    // Next-state rule. A forced FLASH overrides everything. FLASH itself, and
    // any code outside the legal set, falls through to INIT.
    function automatic state_t next_state(input state_t s, input logic [CNT_W-1:0] c,
                                          input logic t, input logic req, input logic fl);
        state_t n;
        n = s;
        case (s)
            ST_INIT:   if (t && c == AR_LAST)        n = ST_MAIN_G;
            ST_MAIN_G: if (t && c == MG_LAST && req) n = ST_MAIN_Y;
            ST_MAIN_Y: if (t && c == MY_LAST)        n = ST_CLR_MS;
            ST_CLR_MS: if (t && c == AR_LAST)        n = ST_SIDE_G;
            ST_SIDE_G: if (t && c == SG_LAST)        n = ST_SIDE_Y;
            ST_SIDE_Y: if (t && c == SY_LAST)        n = ST_CLR_SM;
            ST_CLR_SM: if (t && c == AR_LAST)        n = ST_MAIN_G;
            default:                                 n = ST_INIT;
        endcase
        if (fl) n = ST_FLASH;
        return n;
    endfunction

    // Lamp decode for a given state. Outside FLASH, exactly one lamp per road
    // is lit.
    function automatic logic [5:0] decode(input state_t s, input logic b);
        case (s)
            ST_MAIN_G: decode = 6'b001_100;
            ST_MAIN_Y: decode = 6'b010_100;
            ST_SIDE_G: decode = 6'b100_001;
            ST_SIDE_Y: decode = 6'b100_010;
            ST_FLASH:  decode = {1'b0, b, 1'b0, b, 2'b00};
            default:   decode = LAMPS_ALL_RED;
        endcase
    endfunction

    // NOTE: next-state and next-blink are pure combinational expressions, so the
    // sequential block below contains only non-blocking register updates.
    assign state_nxt = next_state(state, cnt, tick, req_pending, flash_on);
    assign blink_nxt = (state_nxt == ST_FLASH && state != ST_FLASH) ? 1'b1 :
                       (state == ST_FLASH && tick)                  ? ~blink : blink;

    assign phase = state;

    // State, phase timer, request latch and registered lamp outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_INIT;
            cnt         <= '0;
            req_pending <= 1'b0;
            blink       <= 1'b0;
            {main_r, main_y, main_g, side_r, side_y, side_g} <= LAMPS_ALL_RED;
        end else begin
            state <= state_nxt;
            blink <= blink_nxt;
            {main_r, main_y, main_g, side_r, side_y, side_g} <= decode(state_nxt, blink_nxt);

            // The timer restarts on every state change. In main green it
            // saturates at its last value while waiting for a request.
            if (state_nxt != state)
                cnt <= '0;
            else if (tick && !(state == ST_MAIN_G && cnt == MG_LAST))
                cnt <= cnt + 1'b1;

            // Serving the request (entering side green) beats a new request
            // arriving on the same edge.
            if (state_nxt == ST_SIDE_G && state != ST_SIDE_G)
                req_pending <= 1'b0;
            else if (side_req)
                req_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Testbench for traffic_phase_ctrl.
// A behavioural countdown model predicts phase, lamps and req_pending for
// each clock. The prediction is queued when the inputs are driven and popped
// for comparison once the DUT has clocked.
module tb_traffic_phase_ctrl;

    localparam int MG = 8;
    localparam int MY = 3;
    localparam int SG = 5;
    localparam int SY = 3;
    localparam int AR = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       side_req;
    logic       flash;
    logic       main_r, main_y, main_g, side_r, side_y, side_g;
    logic [2:0] phase;
    logic       req_pending;

    traffic_phase_ctrl #(
        .MAIN_GREEN_T (MG),
        .MAIN_YELLOW_T(MY),
        .SIDE_GREEN_T (SG),
        .SIDE_YELLOW_T(SY),
        .ALL_RED_T    (AR),
        .CNT_W        (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .side_req   (side_req),
`ifdef FLASH_MODE_EN
        .flash      (flash),
`endif
        .main_r     (main_r),
        .main_y     (main_y),
        .main_g     (main_g),
        .side_r     (side_r),
        .side_y     (side_y),
        .side_g     (side_g),
        .phase      (phase),
        .req_pending(req_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ph;
        logic [5:0] lamps;
        logic       req;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Model state: phase, ticks remaining in the phase, request latch, blink.
    int   m_ph    = 0;
    int   m_left  = AR;
    int   m_req   = 0;
    int   m_blink = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, act, exp);
        end
    endtask

    function automatic int dur(input int p);
        case (p)
            1:       return MG;
            2:       return MY;
            4:       return SG;
            5:       return SY;
            default: return AR;
        endcase
    endfunction

    function automatic int succ(input int p);
        case (p)
            0:       return 1;
            1:       return 2;
            2:       return 3;
            3:       return 4;
            4:       return 5;
            5:       return 6;
            default: return 1;
        endcase
    endfunction

    // {main_r, main_y, main_g, side_r, side_y, side_g}
    function automatic logic [5:0] lamp_tab(input int p, input int b);
        case (p)
            1:       return 6'b001_100;
            2:       return 6'b010_100;
            4:       return 6'b100_001;
            5:       return 6'b100_010;
            7:       return {1'b0, b[0], 1'b0, b[0], 2'b00};
            default: return 6'b100_100;
        endcase
    endfunction

    // Advance the model by one clock edge with the given inputs.
    task automatic model_edge(input logic t, input logic r, input logic s, input logic f);
        int nph;
        if (r) begin
            m_ph = 0; m_left = AR; m_req = 0; m_blink = 0;
            return;
        end
        nph = m_ph;
        if (t && m_ph != 7) begin
            if (m_left > 1)              m_left--;
            else if (m_ph != 1 || m_req != 0) nph = succ(m_ph);
        end
        if (f)              nph = 7;
        else if (m_ph == 7) nph = 0;
        if (nph == 4 && m_ph != 4) m_req = 0;
        else if (s)                m_req = 1;
        if (nph == 7 && m_ph != 7)   m_blink = 1;
        else if (m_ph == 7 && t)     m_blink = (m_blink == 0) ? 1 : 0;
        if (nph != m_ph) m_left = dur(nph);
        m_ph = nph;
    endtask

    // Drive one cycle of inputs, queue the prediction, clock, then compare.
    task automatic step(input logic t, input logic r, input logic s, input logic f);
        exp_t e;
        @(negedge clk);
        tick = t; rst = r; side_req = s; flash = f;
        model_edge(t, r, s, f);
        e.ph    = 3'(m_ph);
        e.lamps = lamp_tab(m_ph, m_blink);
        e.req   = (m_req != 0);
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = sb.pop_front();
        check("phase", 32'(phase), 32'(e.ph));
        check("lamps", 32'({main_r, main_y, main_g, side_r, side_y, side_g}), 32'(e.lamps));
        check("req_pending", 32'(req_pending), 32'(e.req));
    endtask

    // Run n cycles with side_req held high and a tick every `div` cycles.
    // Check the distance between the first two entries into main green.
    task automatic measure_period(input int n, input int div, input int want);
        int ent[$];
        logic [2:0] prev;
        for (int i = 0; i < n; i++) begin
            prev = phase;
            step((i % div) == 0, 1'b0, 1'b1, 1'b0);
            if (phase == 3'd1 && prev != 3'd1) ent.push_back(cyc);
        end
        if (ent.size() >= 2) check("cycle_period", 32'(ent[1] - ent[0]), 32'(want));
        else                 check("cycle_entries", 32'(ent.size()), 32'd2);
    endtask

    initial begin
        int n;
        rst = 1'b1; tick = 1'b0; side_req = 1'b0; flash = 1'b0;

        // Reset state.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);

        // Idle: two INIT cycles, then main green indefinitely.
        repeat (110) step(1'b1, 1'b0, 1'b0, 1'b0);

        // A one-cycle request at cycle 3 of main green runs a full cycle.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (40) step(1'b1, 1'b0, 1'b0, 1'b0);

        // Request after a long main-green dwell: the saturated timer lets the
        // phase change on the next tick.
        repeat (30) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (30) step(1'b1, 1'b0, 1'b0, 1'b0);

        // Request held high: a 23-cycle loop, and 4x that with a tick every
        // fourth cycle.
        measure_period(80, 1, 23);
        measure_period(300, 4, 92);

        // Reset during side green, with side_req still high.
        n = 0;
        while (phase != 3'd4 && n < 60) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            n++;
        end
        check("reach_side_g", 32'(phase), 32'd4);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);

        // Random tick, request and occasional reset.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0),
                 1'($urandom_range(0, 7) == 0), 1'b0);

`ifdef FLASH_MODE_EN
        // Flash during main yellow, then release back through INIT.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        n = 0;
        while (phase != 3'd2 && n < 40) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            n++;
        end
        check("reach_main_y", 32'(phase), 32'd2);
        for (int i = 0; i < 10; i++) step(1'(i % 2), 1'b0, 1'b1, 1'b1);
        repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0);
        // Reset has priority over flash.
        step(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
